pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ROM_TIMEOUT, default 16: maximum clk cycles spent in FETCH waiting for rom_valid.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  leaves IDLE or HALT when sampled high.
REQ-006 pc  input  11  current program counter value from the program counter block.
REQ-007 rom_addr, rom_req  output  11, 1  fetch address and request to program ROM.
REQ-008 instr, rom_valid  input  16, 1  ROM data and data-valid strobe.
REQ-009 zero  input  1  ALU zero flag used by JZ.
REQ-010 incr  output  1  update strobe to the program counter; the counter acts on its rising edge.
REQ-011 preload, jsr, ret  output  1 each  program-counter mode levels; at most one is high at a time.
REQ-012 addr  output  11  program-counter target or offset.
REQ-013 in_sub, halted, err  output  1 each  subroutine active, sequencer halted, sticky error.

Function
REQ-014 States SHALL be IDLE, FETCH, SETUP, STROBE, HOLD and HALT.
REQ-015 IDLE and start: load a boot preload (preload=1, addr=0) and enter SETUP, so the program counter is forced to 0.
REQ-016 FETCH: rom_req=1 and rom_addr=pc every cycle.
REQ-017 FETCH exit: on the first rising edge with rom_valid=1, capture instr, decode it, drive the mode levels and addr, and enter SETUP.
REQ-018 Decode fields: op=instr[15:11], operand=instr[10:0].
REQ-019 Opcode 5'h10 JMP: preload=1, addr=operand.
REQ-020 Opcode 5'h11 JZ: if zero=1, preload=1 and addr=operand; otherwise no mode level is set (plain increment).
REQ-021 Opcode 5'h12 JSR: jsr=1, addr={1'b0, operand[9:0]}, and set in_sub.
REQ-022 Opcode 5'h13 RET: ret=1 and clear in_sub.
REQ-023 Opcode 5'h1F HALT: no mode level; after HOLD, enter HALT instead of FETCH.
REQ-024 All other opcodes: plain increment, with all mode levels at 0.
REQ-025 JSR while in_sub=1 (the counter stores only one return address): set err and execute as a plain increment.
REQ-026 RET while in_sub=0: set err and execute as a plain increment.
REQ-027 SETUP: incr=0 with mode levels and addr stable.
REQ-028 STROBE: incr=1 with mode levels and addr unchanged.
REQ-029 HOLD: incr=0 with mode levels and addr still unchanged; at the end of HOLD, clear the mode levels and go to FETCH, or to HALT for a HALT opcode.
REQ-030 Mode levels SHALL never change while incr=1 or on the edge where incr rises.
REQ-031 Throughput: 4 clk cycles per instruction when rom_valid is high on the first FETCH cycle, plus 1 cycle per wait cycle.
REQ-032 FETCH timeout: if rom_valid stays low for ROM_TIMEOUT consecutive cycles, set err, drop rom_req and enter HALT with no strobe.
REQ-033 HALT: halted=1, rom_req=0, incr=0.
REQ-034 HALT exit: start resumes at FETCH without preloading; in_sub and err are retained.
REQ-035 incr, the mode levels and addr SHALL be driven from registers, with no combinational path from inputs.
REQ-036 pc wrap-around (11'h7FF+1) is the program counter's behaviour; the sequencer follows whatever pc it reads.

Reset
REQ-037 rst_n low SHALL immediately force state to IDLE.
REQ-038 During reset, incr, preload, jsr, ret, rom_req, in_sub, halted and err are 0, and addr and rom_addr are 11'd0.
REQ-039 Reset mid-STROBE drops incr asynchronously, and the sequencer makes no further program-counter edge.
REQ-040 The program counter itself is not reset by this block; after reset and start, the boot preload (REQ-015) defines pc=0.
REQ-041 start high during reset is ignored.

Verification
REQ-042 Reset, then start, with the ROM returning NOPs -> first strobe has preload=1 and addr=0; the next strobes are plain, and pc reads 0,1,2,3 at successive FETCHes, 4 cycles apart.
REQ-043 instr=16'h8005 (JMP 5) at pc=2 -> preload=1 and addr=5 from SETUP through HOLD; the next rom_addr is 5.
REQ-044 JZ 9 with zero=0, then again with zero=1 -> plain increment first, then preload with addr=9.
REQ-045 JSR offset 4 at pc=3, then RET at pc=7 -> jsr=1 and addr=4 with in_sub=1; then ret=1, in_sub=0 and the next rom_addr is 4; a second JSR while in_sub=1 -> err=1 and a plain increment.
REQ-046 Hold rom_valid low for 16 cycles in FETCH -> err=1, halted=1, rom_req=0, and no incr edge.
REQ-047 Assert rst_n low during STROBE -> incr falls within the same cycle and all outputs match REQ-038.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch/decode sequencer that drives an external
// program counter through registered mode levels and an update strobe.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             leave IDLE (boot preload to 0) or HALT (resume fetching)
//   pc                current program counter value
//   rom_addr, rom_req fetch address / request to program ROM
//   instr, rom_valid  ROM data and data-valid strobe
//   zero              ALU zero flag for JZ
//   incr              program counter update strobe (counter acts on rising edge)
//   preload, jsr, ret program counter mode levels (one-hot or all low)
//   addr              program counter target / offset
//   in_sub, halted    subroutine active, sequencer halted
//   err               sticky error (bad JSR/RET nesting, fetch timeout)
//
// state  | meaning
// IDLE   | after reset, waits for start to boot
// FETCH  | rom_req high, waits for rom_valid, decodes instruction
// SETUP  | mode levels/addr settle, incr low
// STROBE | incr high, counter updates
// HOLD   | incr low, levels held; cleared on exit
// HALT   | stopped, waits for start to resume at FETCH
module pc_sequencer #(
    parameter int ROM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] pc,
    output logic [10:0] rom_addr,
    output logic        rom_req,
    input  logic [15:0] instr,
    input  logic        rom_valid,
    input  logic        zero,
    output logic        incr,
    output logic        preload,
    output logic        jsr,
    output logic        ret,
    output logic [10:0] addr,
    output logic        in_sub,
    output logic        halted,
    output logic        err
);

    localparam int TW = $clog2(ROM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(ROM_TIMEOUT - 1);

    localparam logic [4:0] OP_JMP  = 5'h10;
    localparam logic [4:0] OP_JZ   = 5'h11;
    localparam logic [4:0] OP_JSR  = 5'h12;
    localparam logic [4:0] OP_RET  = 5'h13;
    localparam logic [4:0] OP_HALT = 5'h1F;

    typedef enum logic [2:0] {
        IDLE, FETCH, SETUP, STROBE, HOLD, HALT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            incr_q, incr_d;
    logic            preload_q, preload_d;
    logic            jsr_q, jsr_d;
    logic            ret_q, ret_d;
    logic [10:0]     addr_q, addr_d;
    logic            in_sub_q, in_sub_d;
    logic            err_q, err_d;
    logic            halt_op_q, halt_op_d;

    logic [4:0]      op;
    logic [10:0]     operand;

    assign op      = instr[15:11];
    assign operand = instr[10:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            incr_q    <= 1'b0;
            preload_q <= 1'b0;
            jsr_q     <= 1'b0;
            ret_q     <= 1'b0;
            addr_q    <= '0;
            in_sub_q  <= 1'b0;
            err_q     <= 1'b0;
            halt_op_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            incr_q    <= incr_d;
            preload_q <= preload_d;
            jsr_q     <= jsr_d;
            ret_q     <= ret_d;
            addr_q    <= addr_d;
            in_sub_q  <= in_sub_d;
            err_q     <= err_d;
            halt_op_q <= halt_op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        incr_d    = 1'b0;
        preload_d = preload_q;
        jsr_d     = jsr_q;
        ret_d     = ret_q;
        addr_d    = addr_q;
        in_sub_d  = in_sub_q;
        err_d     = err_q;
        halt_op_d = halt_op_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Boot preload forces the external counter to 0.
                    preload_d = 1'b1;
                    jsr_d     = 1'b0;
                    ret_d     = 1'b0;
                    addr_d    = '0;
                    halt_op_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            FETCH: begin
                if (rom_valid) begin
                    preload_d = 1'b0;
                    jsr_d     = 1'b0;
                    ret_d     = 1'b0;
                    addr_d    = '0;
                    halt_op_d = 1'b0;
                    case (op)
                        OP_JMP: begin
                            preload_d = 1'b1;
                            addr_d    = operand;
                        end
                        OP_JZ: begin
                            if (zero) begin
                                preload_d = 1'b1;
                                addr_d    = operand;
                            end
                        end
                        OP_JSR: begin
                            // Only one return address fits in the counter.
                            if (in_sub_q) begin
                                err_d = 1'b1;
                            end else begin
                                jsr_d    = 1'b1;
                                addr_d   = {1'b0, operand[9:0]};
                                in_sub_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!in_sub_q) begin
                                err_d = 1'b1;
                            end else begin
                                ret_d    = 1'b1;
                                in_sub_d = 1'b0;
                            end
                        end
                        OP_HALT: halt_op_d = 1'b1;
                        default: ;
                    endcase
                    state_d = SETUP;
                end else if (timer_q == '0) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SETUP: begin
                incr_d  = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                preload_d = 1'b0;
                jsr_d     = 1'b0;
                ret_d     = 1'b0;
                timer_d   = TMR_LOAD;
                state_d   = halt_op_q ? HALT : FETCH;
            end
            HALT: begin
                if (start) begin
                    timer_d = TMR_LOAD;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_req  = (state_q == FETCH);
    assign rom_addr = rom_req ? pc : '0;
    assign halted   = (state_q == HALT);
    assign incr     = incr_q;
    assign preload  = preload_q;
    assign jsr      = jsr_q;
    assign ret      = ret_q;
    assign addr     = addr_q;
    assign in_sub   = in_sub_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a behavioural
// program counter and ROM around the DUT.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        zero = 1'b0;
    logic        valid_en = 1'b1;
    logic [10:0] pc = 11'h7FF;
    logic [10:0] ret_pc = 11'd0;
    logic [10:0] rom_addr, addr;
    logic        rom_req, rom_valid, incr, preload, jsr, ret, in_sub, halted, err;
    logic [15:0] instr;
    logic [15:0] rom [0:2047];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int incr_edges = 0;

    pc_sequencer #(.ROM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
        .rom_addr(rom_addr), .rom_req(rom_req), .instr(instr),
        .rom_valid(rom_valid), .zero(zero), .incr(incr),
        .preload(preload), .jsr(jsr), .ret(ret), .addr(addr),
        .in_sub(in_sub), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural program counter: acts on the rising edge of incr.
    always @(posedge incr) begin
        incr_edges++;
        if (preload) pc <= addr;
        else if (jsr) begin
            ret_pc <= pc + 11'd1;
            pc     <= pc + addr;
        end else if (ret) pc <= ret_pc;
        else pc <= pc + 11'd1;
    end

    assign rom_valid = rom_req & valid_en;
    assign instr     = rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check_eq(tag, {incr, preload, jsr, ret, rom_req, in_sub, halted, err, addr, rom_addr}, 32'd0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset_outs");
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    // Called at the negedge of the deciding cycle; checks SETUP, STROBE, HOLD.
    task automatic chk_instr(input string tag, input logic p, input logic j, input logic r,
                             input logic [10:0] a, input logic use_a);
        @(negedge clk);
        check_eq({tag, "_setup"}, {incr, preload, jsr, ret}, {1'b0, p, j, r});
        if (use_a) check_eq({tag, "_setup_addr"}, addr, a);
        @(negedge clk);
        check_eq({tag, "_strobe"}, {incr, preload, jsr, ret}, {1'b1, p, j, r});
        if (use_a) check_eq({tag, "_strobe_addr"}, addr, a);
        @(negedge clk);
        check_eq({tag, "_hold"}, {incr, preload, jsr, ret}, {1'b0, p, j, r});
    endtask

    task automatic wait_fetch(input string tag, input logic [10:0] exp_pc);
        int n = 0;
        @(negedge clk);
        while (!rom_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, rom_req, 1);
        check_eq({tag, "_rom_addr"}, rom_addr, exp_pc);
    endtask

    task automatic boot(input string tag);
        start = 1'b1;
        chk_instr(tag, 1'b1, 1'b0, 1'b0, 11'd0, 1'b1);
        start = 1'b0;
    endtask

    initial begin
        int t0;
        int e0;

        // Phase A: NOPs, boot preload, 4-cycle throughput.
        clear_rom();
        do_reset();
        boot("boot");
        wait_fetch("a_f0", 11'd0);
        t0 = cyc;
        for (int i = 1; i < 4; i++) begin
            chk_instr("a_nop", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
            wait_fetch("a_f", 11'(i));
            check_eq("a_period", cyc - t0, 4);
            t0 = cyc;
        end

        // Phase B: JMP 5 at pc=2, JZ 9 with zero=0 then zero=1.
        clear_rom();
        rom[2] = 16'h8005;
        rom[5] = 16'h8809;
        rom[6] = 16'h8809;
        do_reset();
        boot("b_boot");
        for (int i = 0; i < 2; i++) begin
            wait_fetch("b_f", 11'(i));
            chk_instr("b_nop", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        end
        wait_fetch("b_f2", 11'd2);
        chk_instr("jmp", 1'b1, 1'b0, 1'b0, 11'd5, 1'b1);
        wait_fetch("b_f5", 11'd5);
        zero = 1'b0;
        chk_instr("jz_nz", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        wait_fetch("b_f6", 11'd6);
        zero = 1'b1;
        chk_instr("jz_z", 1'b1, 1'b0, 1'b0, 11'd9, 1'b1);
        zero = 1'b0;
        wait_fetch("b_f9", 11'd9);

        // Phase C: JSR/RET, nested JSR error, HALT and resume.
        clear_rom();
        rom[3] = 16'h9004;
        rom[7] = 16'h9800;
        rom[4] = 16'h9004;
        rom[8] = 16'h9004;
        rom[9] = 16'hF800;
        do_reset();
        boot("c_boot");
        for (int i = 0; i < 3; i++) begin
            wait_fetch("c_f", 11'(i));
            chk_instr("c_nop", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        end
        wait_fetch("c_f3", 11'd3);
        chk_instr("jsr", 1'b0, 1'b1, 1'b0, 11'd4, 1'b1);
        check_eq("jsr_in_sub", in_sub, 1);
        wait_fetch("c_f7", 11'd7);
        chk_instr("ret", 1'b0, 1'b0, 1'b1, 11'd0, 1'b0);
        check_eq("ret_in_sub", in_sub, 0);
        check_eq("ret_err", err, 0);
        wait_fetch("c_f4", 11'd4);
        chk_instr("jsr2", 1'b0, 1'b1, 1'b0, 11'd4, 1'b1);
        check_eq("jsr2_in_sub", in_sub, 1);
        wait_fetch("c_f8", 11'd8);
        chk_instr("jsr_nested", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        check_eq("nested_err", {err, in_sub}, 2'b11);
        wait_fetch("c_f9", 11'd9);
        chk_instr("halt_op", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
        @(negedge clk);
        check_eq("halt_state", {halted, rom_req, incr}, 3'b100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("resume_fetch", {rom_req, halted, in_sub, err}, 4'b1011);
        check_eq("resume_addr", rom_addr, 11'd10);
        chk_instr("resume_nop", 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);

        // Phase D: fetch timeout after 16 cycles without rom_valid.
        clear_rom();
        do_reset();
        boot("d_boot");
        valid_en = 1'b0;
        wait_fetch("d_f0", 11'd0);
        e0 = incr_edges;
        repeat (15) @(negedge clk);
        check_eq("to_not_early", {rom_req, halted, err}, 3'b100);
        @(negedge clk);
        check_eq("to_halt", {rom_req, halted, err}, 3'b011);
        repeat (3) @(negedge clk);
        check_eq("to_no_incr", incr_edges, e0);
        valid_en = 1'b1;

        // Phase E: reset during STROBE.
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("e_strobe", incr, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("e_rst_async");
        e0 = incr_edges;
        repeat (3) @(negedge clk);
        check_eq("e_no_edge", incr_edges, e0);
        chk_zero("e_rst_hold");
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
